tt_um_nibble_acc: RTL

TT_UM_NIBBLE_ACC -- requirements
Module: tt_um_nibble_acc

---
 rtl/tt_um_nibble_acc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tt_um_nibble_acc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tt_um_nibble_acc
// Description : Strobed nibble-pair accumulator. Each strobe adds A+B into a
//               saturating 12-bit accumulator and an 8-bit add counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_nibble_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_stb_sync;
    logic [1:0]  r_clr_sync;
    logic [3:0]  r_op_a;
    logic [3:0]  r_op_b;
    logic [11:0] r_acc;
    logic [7:0]  r_count;
    logic        r_ovf;
    logic        r_cnt_sat;

    logic        w_stb_rise;
    logic        w_clear;
    logic        w_capture;
    logic        w_add;
    logic        w_busy;
    logic        w_done;
    logic [12:0] w_acc_sum;
    logic [8:0]  w_cnt_sum;
    logic [4:0]  w_live_sum;
    logic        w_unused;

    // Pad inputs are asynchronous; bit 2 of the strobe chain only feeds edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_sync <= 3'b000;
            r_clr_sync <= 2'b00;
        end else begin
            r_stb_sync <= {r_stb_sync[1:0], uio_in[0]};
            r_clr_sync <= {r_clr_sync[0], uio_in[1]};
        end
    end

    assign w_stb_rise = r_stb_sync[1] & ~r_stb_sync[2];
    assign w_clear    = r_clr_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobes seen outside IDLE are simply not acted on, so they are dropped.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_add        = 1'b0;
        if (w_clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_stb_rise) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_ADD;
                    end
                end
                ST_ADD: begin
                    w_add        = 1'b1;
                    w_state_next = ST_DONE;
                end
                ST_DONE: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_acc_sum = {1'b0, r_acc} + {9'd0, r_op_a} + {9'd0, r_op_b};
    assign w_cnt_sum = {1'b0, r_count} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a    <= 4'd0;
            r_op_b    <= 4'd0;
            r_acc     <= 12'd0;
            r_count   <= 8'd0;
            r_ovf     <= 1'b0;
            r_cnt_sat <= 1'b0;
        end else if (w_clear) begin
            r_op_a    <= 4'd0;
            r_op_b    <= 4'd0;
            r_acc     <= 12'd0;
            r_count   <= 8'd0;
            r_ovf     <= 1'b0;
            r_cnt_sat <= 1'b0;
        end else if (w_capture) begin
            r_op_a <= ui_in[3:0];
            r_op_b <= ui_in[7:4];
        end else if (w_add) begin
            if (w_acc_sum[12]) begin
                r_acc <= 12'hFFF;
                r_ovf <= 1'b1;
            end else begin
                r_acc <= w_acc_sum[11:0];
            end
            if (w_cnt_sum[8]) begin
                r_count   <= 8'hFF;
                r_cnt_sat <= 1'b1;
            end else begin
                r_count <= w_cnt_sum[7:0];
            end
        end
    end

    assign w_busy     = (r_state != ST_IDLE);
    assign w_done     = (r_state == ST_DONE);
    assign w_live_sum = {1'b0, ui_in[3:0]} + {1'b0, ui_in[7:4]};

    always_comb begin
        uo_out = 8'h00;
        case (uio_in[3:2])
            2'b00:   uo_out = r_acc[7:0];
            2'b01:   uo_out = {r_ovf, r_cnt_sat, w_busy, 1'b0, r_acc[11:8]};
            2'b10:   uo_out = r_count;
            default: uo_out = {3'b000, w_live_sum};
        endcase
    end

    assign uio_out = {w_busy, w_done, r_ovf, r_cnt_sat, 4'b0000};
    assign uio_oe  = 8'hF0;

    assign w_unused = &{1'b0, ena, uio_in[7:4]};

endmodule
`default_nettype wire
